// File: rtl/fifo_wr_ptr_pkt.sv
// Write-side pointer logic for a packet FIFO. Words are written speculatively and
// only published to the read domain (wr_ptr) once the closing word of a frame lands.
module fifo_wr_ptr_pkt #(
   parameter int ADDR_WIDTH       = 8,
   parameter int ALMOST_FULL_DIFF = 50
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  write,
   input  logic                  frame_end,
   input  logic                  frame_drop,
   input  logic [ADDR_WIDTH:0]   rd_ptr,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic                  wr_en,
   output logic [ADDR_WIDTH:0]   wr_ptr,
   output logic                  full,
   output logic                  almost_full,
   output logic                  frame_committed,
   output logic                  frame_dropped
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] AF_LEVEL = (ADDR_WIDTH+1)'(DEPTH - ALMOST_FULL_DIFF);

   typedef enum logic [1:0] {IDLE, WRITING, DROP} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH:0]   wr_bin_q, wr_bin_d;
   logic [ADDR_WIDTH:0]   cm_bin_q, cm_bin_d;
   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic                  full_q, full_d;
   logic                  almost_full_q, almost_full_d;
   logic                  committed_q, committed_d;
   logic                  dropped_q, dropped_d;
   logic [ADDR_WIDTH:0]   rd_bin;

   function automatic logic [ADDR_WIDTH:0] bin2gray(input logic [ADDR_WIDTH:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
      logic [ADDR_WIDTH:0] b;
      b[ADDR_WIDTH] = g[ADDR_WIDTH];
      for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   assign rd_bin = gray2bin(rd_ptr);
   assign wr_en  = write & ~full_q & ~frame_drop & (state_q != DROP);

   always_comb begin
      state_d     = state_q;
      wr_bin_d    = wr_bin_q;
      cm_bin_d    = cm_bin_q;
      wr_ptr_d    = wr_ptr_q;
      committed_d = 1'b0;
      dropped_d   = 1'b0;

      if (frame_drop) begin
         wr_bin_d  = cm_bin_q;
         state_d   = IDLE;
         dropped_d = (state_q != IDLE);
      end else if (state_q == DROP) begin
         // Remainder of an overflowed frame is swallowed until its last word.
         if (write && frame_end) begin
            dropped_d = 1'b1;
            state_d   = IDLE;
         end
      end else if (write && full_q) begin
         wr_bin_d = cm_bin_q;
         if (frame_end) begin
            dropped_d = 1'b1;
            state_d   = IDLE;
         end else begin
            state_d = DROP;
         end
      end else if (write) begin
         wr_bin_d = wr_bin_q + 1'b1;
         if (frame_end) begin
            cm_bin_d    = wr_bin_d;
            wr_ptr_d    = bin2gray(wr_bin_d);
            committed_d = 1'b1;
            state_d     = IDLE;
         end else begin
            state_d = WRITING;
         end
      end

      // Full when the working pointer sits exactly one lap ahead of the reader.
      full_d        = (bin2gray(wr_bin_d) ==
                       {~rd_ptr[ADDR_WIDTH:ADDR_WIDTH-1], rd_ptr[ADDR_WIDTH-2:0]});
      almost_full_d = ((wr_bin_d - rd_bin) >= AF_LEVEL);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         wr_bin_q      <= '0;
         cm_bin_q      <= '0;
         wr_ptr_q      <= '0;
         full_q        <= 1'b0;
         almost_full_q <= 1'b0;
         committed_q   <= 1'b0;
         dropped_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_bin_q      <= wr_bin_d;
         cm_bin_q      <= cm_bin_d;
         wr_ptr_q      <= wr_ptr_d;
         full_q        <= full_d;
         almost_full_q <= almost_full_d;
         committed_q   <= committed_d;
         dropped_q     <= dropped_d;
      end
   end

   assign wr_addr         = wr_bin_q[ADDR_WIDTH-1:0];
   assign wr_ptr          = wr_ptr_q;
   assign full            = full_q;
   assign almost_full     = almost_full_q;
   assign frame_committed = committed_q;
   assign frame_dropped   = dropped_q;

endmodule

// File: tb/tb_fifo_wr_ptr_pkt.sv
// Bench for fifo_wr_ptr_pkt: fixed vector table, directed corner sequences and a
// randomized run against an occupancy-count reference model.
module tb_fifo_wr_ptr_pkt;

   localparam int AW  = 8;
   localparam int D   = 256;
   localparam int PM  = 512;
   localparam int AFD = 50;

   logic          clk = 1'b0;
   logic          reset, write, frame_end, frame_drop;
   logic [AW:0]   rd_ptr;
   logic [AW-1:0] wr_addr;
   logic          wr_en;
   logic [AW:0]   wr_ptr;
   logic          full, almost_full, frame_committed, frame_dropped;

   fifo_wr_ptr_pkt #(.ADDR_WIDTH(AW), .ALMOST_FULL_DIFF(AFD)) dut (
      .clk(clk), .reset(reset), .write(write), .frame_end(frame_end),
      .frame_drop(frame_drop), .rd_ptr(rd_ptr), .wr_addr(wr_addr), .wr_en(wr_en),
      .wr_ptr(wr_ptr), .full(full), .almost_full(almost_full),
      .frame_committed(frame_committed), .frame_dropped(frame_dropped)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: absolute word counts, not pointer registers.
   int unsigned m_cm, m_pend, m_rd;
   bit          m_dropping, m_full, m_af, m_cp, m_dp;
   logic        last_en;
   logic [31:0] last_addr;
   int          dp_seen, cp_seen;

   function automatic logic [AW:0] gray(input int unsigned b);
      logic [AW:0] x;
      x = b[AW:0];
      return x ^ (x >> 1);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cm = 0; m_pend = 0; m_dropping = 0;
      m_full = 0; m_af = 0; m_cp = 0; m_dp = 0;
   endtask

   task automatic step(input bit rs, input bit w, input bit fe, input bit fd);
      int unsigned occ;
      reset = rs; write = w; frame_end = fe; frame_drop = fd;
      rd_ptr = gray(m_rd);
      #1;
      last_en   = wr_en;
      last_addr = 32'(wr_addr);
      if (!rs) begin
         check("wr_en", 32'(wr_en), 32'(w && !m_full && !fd && !m_dropping));
         check("wr_addr", 32'(wr_addr), (m_cm + m_pend) % D);
      end
      @(posedge clk);
      if (rs) begin
         model_reset();
      end else begin
         m_cp = 0; m_dp = 0;
         if (fd) begin
            m_dp = (m_pend > 0) || m_dropping;
            m_pend = 0; m_dropping = 0;
         end else if (m_dropping) begin
            if (w && fe) begin m_dp = 1; m_dropping = 0; end
         end else if (w && m_full) begin
            m_pend = 0;
            if (fe) m_dp = 1; else m_dropping = 1;
         end else if (w) begin
            m_pend++;
            if (fe) begin m_cm += m_pend; m_pend = 0; m_cp = 1; end
         end
         occ    = (m_cm + m_pend - m_rd) % PM;
         m_full = (occ == D);
         m_af   = (occ >= D - AFD);
      end
      #1;
      check("wr_ptr", 32'(wr_ptr), 32'(gray(m_cm)));
      check("full", 32'(full), 32'(m_full));
      check("almost_full", 32'(almost_full), 32'(m_af));
      check("frame_committed", 32'(frame_committed), 32'(m_cp));
      check("frame_dropped", 32'(frame_dropped), 32'(m_dp));
      dp_seen += int'(frame_dropped);
      cp_seen += int'(frame_committed);
   endtask

   typedef struct {
      bit rs, w, fe, fd;
      bit en;
      int addr;
      int wptr;
      bit cm, dp;
   } vec_t;

   vec_t tbl[14];

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      m_rd = 0; dp_seen = 0; cp_seen = 0;
      model_reset();

      //           rs w  fe fd en addr wptr cm dp
      tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{0, 1, 0, 0, 1, 0, 0, 0, 0};
      tbl[2]  = '{0, 1, 0, 0, 1, 1, 0, 0, 0};
      tbl[3]  = '{0, 1, 0, 0, 1, 2, 0, 0, 0};
      tbl[4]  = '{0, 1, 1, 0, 1, 3, 6, 1, 0};
      tbl[5]  = '{0, 0, 0, 0, 0, 4, 6, 0, 0};
      tbl[6]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[7]  = '{0, 1, 0, 0, 1, 0, 0, 0, 0};
      tbl[8]  = '{0, 1, 0, 0, 1, 1, 0, 0, 0};
      tbl[9]  = '{0, 1, 0, 0, 1, 2, 0, 0, 0};
      tbl[10] = '{0, 1, 1, 1, 0, 3, 0, 0, 1};
      tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[12] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
      tbl[13] = '{0, 1, 1, 0, 1, 0, 1, 1, 0};

      for (int i = 0; i < 14; i++) begin
         step(tbl[i].rs, tbl[i].w, tbl[i].fe, tbl[i].fd);
         if (!tbl[i].rs) begin
            check($sformatf("tbl%0d_en", i), 32'(last_en), 32'(tbl[i].en));
            check($sformatf("tbl%0d_addr", i), last_addr, 32'(tbl[i].addr));
         end
         check($sformatf("tbl%0d_wptr", i), 32'(wr_ptr), 32'(tbl[i].wptr));
         check($sformatf("tbl%0d_commit", i), 32'(frame_committed), 32'(tbl[i].cm));
         check($sformatf("tbl%0d_drop", i), 32'(frame_dropped), 32'(tbl[i].dp));
      end

      // Whole-FIFO frame fills to full, then the next write is refused.
      m_rd = 0; step(1, 0, 0, 0);
      for (int i = 0; i < 256; i++) step(0, 1, (i == 255), 0);
      check("fill_full", 32'(full), 1);
      check("fill_wrptr", 32'(wr_ptr), 384);
      step(0, 1, 0, 0);
      check("fill_257_rejected", 32'(last_en), 0);
      step(0, 1, 1, 0);
      check("fill_tail_dropped", 32'(frame_dropped), 1);

      // Overflow mid-frame rewinds to the committed point and drops the frame.
      m_rd = 0; step(1, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 1, (i == 9), 0);
      for (int i = 0; i < 246; i++) step(0, 1, 0, 0);
      check("ovf_full", 32'(full), 1);
      dp_seen = 0;
      step(0, 1, 0, 0);
      check("ovf_rewind_addr", 32'(wr_addr), 10);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
      step(0, 1, 1, 0);
      check("ovf_drop_pulses", 32'(dp_seen), 1);
      check("ovf_wrptr_kept", 32'(wr_ptr), 32'(gray(10)));

      // Almost-full threshold and its release when the reader moves on.
      m_rd = 0; step(1, 0, 0, 0);
      for (int i = 0; i < 206; i++) step(0, 1, (i == 205), 0);
      check("af_set", 32'(almost_full), 1);
      m_rd = 1; step(0, 0, 0, 0);
      check("af_clear", 32'(almost_full), 0);

      // Wrap of the 9-bit pointer with the FIFO kept nearly empty.
      m_rd = 0; step(1, 0, 0, 0);
      for (int i = 0; i < 510; i++) begin
         m_rd = m_cm;
         step(0, 1, 1, 0);
      end
      m_rd = 510;
      for (int i = 0; i < 4; i++) begin
         step(0, 1, (i == 3), 0);
         check($sformatf("wrap_addr%0d", i), last_addr, (254 + i) % D);
         check($sformatf("wrap_full%0d", i), 32'(full), 0);
      end
      check("wrap_wrptr", 32'(wr_ptr), 3);

      // Randomized traffic with alternating slow and fast reader phases.
      m_rd = 0; step(1, 0, 0, 0);
      for (int c = 0; c < 4000; c++) begin
         bit slow;
         int unsigned room;
         slow = ((c / 300) % 2) == 0;
         room = m_cm - m_rd;
         if (room > 0) begin
            if (slow && ($urandom % 8 == 0)) m_rd += 1;
            else if (!slow && ($urandom % 2 == 0))
               m_rd += (room < 4) ? room : $urandom_range(1, 4);
         end
         if ($urandom % 1000 == 0) begin
            m_rd = 0;
            step(1, 0, 0, 0);
         end else begin
            step(0, ($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 40) == 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_wr_ptr_pkt.md
FIFO_WR_PTR_PKT -- requirements
Module: fifo_wr_ptr_pkt

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: memory address width; FIFO depth DEPTH = 2^ADDR_WIDTH.
REQ-002 SHALL have parameter ALMOST_FULL_DIFF, default 50: free-entry threshold for almost_full.
REQ-003 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port write  input  1: a word is presented for writing this cycle.
REQ-006 SHALL have port frame_end  input  1: qualifies write; the presented word is the last of its frame.
REQ-007 SHALL have port frame_drop  input  1: abort current frame, discard all uncommitted words.
REQ-008 SHALL have port rd_ptr  input  ADDR_WIDTH+1: Gray-coded read pointer, already synchronised into clk domain.
REQ-009 SHALL have port wr_addr  output  ADDR_WIDTH: binary memory write address (working pointer LSBs).
REQ-010 SHALL have port wr_en  output  1: memory write strobe, combinational = accepted word this cycle.
REQ-011 SHALL have port wr_ptr  output  ADDR_WIDTH+1: registered Gray-coded committed pointer, passed to read domain.
REQ-012 SHALL have port full  output  1: registered, no free entries for working pointer.
REQ-013 SHALL have port almost_full  output  1: registered, free entries <= ALMOST_FULL_DIFF.
REQ-014 SHALL have port frame_committed  output  1: one-cycle pulse, a frame was published.
REQ-015 SHALL have port frame_dropped  output  1: one-cycle pulse, a frame was discarded.

Function
REQ-016 SHALL keep two binary ADDR_WIDTH+1 pointers: working (wr_bin) and committed (cm_bin); wr_addr = wr_bin[ADDR_WIDTH-1:0].
REQ-017 SHALL convert rd_ptr Gray->binary (MSB copied, each lower bit = next-higher binary bit XOR Gray bit) for occupancy arithmetic.
REQ-018 SHALL implement FSM states IDLE (no uncommitted words), WRITING (uncommitted words held), DROP (discarding rest of overflowed frame).
REQ-019 SHALL accept a word (wr_en=1) only when write=1, full=0, frame_drop=0, state!=DROP; accepted word increments wr_bin by 1 next cycle.
REQ-020 SHALL, on accepted word with frame_end=1, set cm_bin and wr_ptr to Gray(wr_bin+1) next cycle, pulse frame_committed, go IDLE.
REQ-021 SHALL, on accepted word with frame_end=0, go/stay WRITING.
REQ-022 SHALL, on write=1 with full=1 in IDLE/WRITING (overflow), restore wr_bin to cm_bin; if frame_end=1 pulse frame_dropped and go IDLE, else go DROP.
REQ-023 SHALL, in DROP, ignore write words; write=1 with frame_end=1 pulses frame_dropped and goes IDLE.
REQ-024 SHALL, on frame_drop=1 in any state, restore wr_bin to cm_bin, go IDLE, pulse frame_dropped if state was WRITING or DROP; frame_drop overrides write/frame_end same cycle.
REQ-025 SHALL register full = (Gray(wr_bin_next) == {~rd_ptr[ADDR_WIDTH:ADDR_WIDTH-1], rd_ptr[ADDR_WIDTH-2:0]}), wr_bin_next being next-cycle working value.
REQ-026 SHALL register almost_full = ((wr_bin_next - rd_bin) mod 2^(ADDR_WIDTH+1)) >= DEPTH - ALMOST_FULL_DIFF.
REQ-027 SHALL use modulo-2^(ADDR_WIDTH+1) arithmetic for all pointers; wrap-around needs no special case.
REQ-028 SHALL never publish uncommitted words: wr_ptr changes only on commit, never on drop/rewind.
REQ-029 SHALL allow full to deassert the cycle after rd_ptr advance makes room (one-cycle registered latency).

Reset
REQ-030 SHALL, with reset=1 at clk edge, set wr_bin=cm_bin=0, wr_ptr=0, full=0, almost_full=0, frame_committed=0, frame_dropped=0, state IDLE.
REQ-031 SHALL give reset priority over all inputs; reset mid-frame discards uncommitted words without frame_dropped pulse.

Verification
REQ-032 SHALL cover: 4-word frame, rd_ptr=0 -> wr_addr 0..3, wr_ptr=Gray(4)=6 one cycle after 4th word, one frame_committed pulse.
REQ-033 SHALL cover: 3 words then frame_drop -> wr_addr returns to 0, wr_ptr stays 0, frame_dropped pulse, no frame_committed.
REQ-034 SHALL cover: DEPTH=256, rd_ptr=0, 256-word frame with frame_end on word 256 -> full=1 after word 256, commit, wr_ptr=Gray(256); 257th write rejected.
REQ-035 SHALL cover: frame overflow at full mid-frame -> wr_bin back to cm_bin, DROP until frame_end, one frame_dropped, wr_ptr unchanged.
REQ-036 SHALL cover: 206 committed words, rd_ptr=0 -> almost_full=1 (free=50); rd_ptr advanced by 1 -> almost_full=0 next cycle.
REQ-037 SHALL cover: pointer wrap (cm_bin=510, 4-word frame) -> wr_addr 254,255,0,1, wr_ptr=Gray(2)=3, full never set.
